// File: rtl/lsu_pkg.sv
// Shared funct3 encodings, FSM state type and access-check helpers for the load/store unit.
`timescale 1ns/1ps

package lsu_pkg;

    // RISC-V load/store width encodings (funct3)
    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10,
        ST_RESP = 2'b11
    } lsu_state_t;

    // Unknown encodings are illegal; unsigned widths only exist for loads.
    function automatic logic lsu_illegal(input logic [2:0] funct3, input logic store);
        logic bad;
        case (funct3)
            LSU_B, LSU_H, LSU_W: bad = 1'b0;
            LSU_BU, LSU_HU:      bad = store;
            default:             bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Halfwords need an even address, words a word-aligned one; bytes never fault.
    function automatic logic lsu_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic mis;
        case (funct3)
            LSU_H, LSU_HU: mis = addr_lo[0];
            LSU_W:         mis = (addr_lo != 2'b00);
            default:       mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, replicated store data, access fault flag
// and load-data extraction with sign/zero extension.
`timescale 1ns/1ps

module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic        store,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] lane_wdata,
    output logic        fault,
    output logic [31:0] load_data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    assign fault = lsu_illegal(funct3, store) | lsu_misaligned(funct3, addr_lo);

    // Byte enables and lane-replicated store data from access width and address
    always_comb begin
        be         = 4'b0000;
        lane_wdata = 32'h0000_0000;
        case (funct3[1:0])
            2'b00: begin
                be         = 4'b0001 << addr_lo;
                lane_wdata = {4{wdata[7:0]}};
            end
            2'b01: begin
                if (addr_lo[1]) begin
                    be = 4'b1100;
                end else begin
                    be = 4'b0011;
                end
                lane_wdata = {2{wdata[15:0]}};
            end
            2'b10: begin
                be         = 4'b1111;
                lane_wdata = wdata;
            end
            default: begin
                be         = 4'b0000;
                lane_wdata = 32'h0000_0000;
            end
        endcase
    end

    // Pick the addressed byte and halfword out of the returned word
    always_comb begin
        byte_s = 8'h00;
        half_s = 16'h0000;
        case (addr_lo)
            2'b00:   byte_s = rdata[7:0];
            2'b01:   byte_s = rdata[15:8];
            2'b10:   byte_s = rdata[23:16];
            2'b11:   byte_s = rdata[31:24];
            default: byte_s = 8'h00;
        endcase
        if (addr_lo[1]) begin
            half_s = rdata[31:16];
        end else begin
            half_s = rdata[15:0];
        end
    end

    // Extend the selected lane to 32 bits according to the load type
    always_comb begin
        load_data = 32'h0000_0000;
        case (funct3)
            LSU_B:   load_data = {{24{byte_s[7]}}, byte_s};
            LSU_H:   load_data = {{16{half_s[15]}}, half_s};
            LSU_W:   load_data = rdata;
            LSU_BU:  load_data = {24'h00_0000, byte_s};
            LSU_HU:  load_data = {16'h0000, half_s};
            default: load_data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one outstanding request on a grant/valid data-memory port,
// returning an extended load value, a store completion or an access fault.
`timescale 1ns/1ps

module lsu
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_fault
);

    lsu_state_t  state_r, next_s;

    // Latched op attributes needed after acceptance (load extraction)
    logic        store_r,   store_n_s;
    logic [2:0]  funct3_r,  funct3_n_s;
    logic [1:0]  addr_lo_r, addr_lo_n_s;

    // Registered outputs and their next values
    logic        req_ready_r, req_ready_n_s;
    logic        mem_req_r,   mem_req_n_s;
    logic        mem_we_r,    mem_we_n_s;
    logic [31:0] mem_addr_r,  mem_addr_n_s;
    logic [3:0]  mem_be_r,    mem_be_n_s;
    logic [31:0] mem_wdata_r, mem_wdata_n_s;
    logic        rsp_valid_r, rsp_valid_n_s;
    logic [31:0] rsp_data_r,  rsp_data_n_s;
    logic        rsp_fault_r, rsp_fault_n_s;

    // Alignment helper inputs/outputs
    logic [2:0]  al_funct3_s;
    logic        al_store_s;
    logic [1:0]  al_addr_lo_s;
    logic [3:0]  al_be_s;
    logic [31:0] al_wdata_s;
    logic        al_fault_s;
    logic [31:0] al_load_s;

    // In IDLE the helper sees the incoming op; afterwards it sees the latched op
    always_comb begin
        al_funct3_s  = funct3_r;
        al_store_s   = store_r;
        al_addr_lo_s = addr_lo_r;
        if (state_r == ST_IDLE) begin
            al_funct3_s  = req_funct3;
            al_store_s   = req_store;
            al_addr_lo_s = req_addr[1:0];
        end else begin
            al_funct3_s  = funct3_r;
            al_store_s   = store_r;
            al_addr_lo_s = addr_lo_r;
        end
    end

    lsu_align u_align (
        .funct3     (al_funct3_s),
        .store      (al_store_s),
        .addr_lo    (al_addr_lo_s),
        .wdata      (req_wdata),
        .rdata      (mem_rdata),
        .be         (al_be_s),
        .lane_wdata (al_wdata_s),
        .fault      (al_fault_s),
        .load_data  (al_load_s)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state logic
    always_comb begin
        next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    if (al_fault_s) begin
                        next_s = ST_RESP;
                    end else begin
                        next_s = ST_REQ;
                    end
                end else begin
                    next_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (mem_gnt) begin
                    if (store_r) begin
                        next_s = ST_RESP;
                    end else begin
                        next_s = ST_WAIT;
                    end
                end else begin
                    next_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (mem_rvalid) begin
                    next_s = ST_RESP;
                end else begin
                    next_s = ST_WAIT;
                end
            end
            ST_RESP: next_s = ST_IDLE;
            default: next_s = ST_IDLE;
        endcase
    end

    // Output decode: next values of all registered outputs and latched op fields
    always_comb begin
        store_n_s     = store_r;
        funct3_n_s    = funct3_r;
        addr_lo_n_s   = addr_lo_r;
        mem_req_n_s   = mem_req_r;
        mem_we_n_s    = mem_we_r;
        mem_addr_n_s  = mem_addr_r;
        mem_be_n_s    = mem_be_r;
        mem_wdata_n_s = mem_wdata_r;
        rsp_valid_n_s = 1'b0;
        rsp_data_n_s  = rsp_data_r;
        rsp_fault_n_s = rsp_fault_r;
        req_ready_n_s = (next_s == ST_IDLE);
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    store_n_s   = req_store;
                    funct3_n_s  = req_funct3;
                    addr_lo_n_s = req_addr[1:0];
                    if (al_fault_s) begin
                        // Faulting ops never reach memory
                        mem_req_n_s   = 1'b0;
                        rsp_valid_n_s = 1'b1;
                        rsp_fault_n_s = 1'b1;
                        rsp_data_n_s  = 32'h0000_0000;
                    end else begin
                        mem_req_n_s   = 1'b1;
                        mem_we_n_s    = req_store;
                        mem_addr_n_s  = {req_addr[31:2], 2'b00};
                        mem_be_n_s    = al_be_s;
                        mem_wdata_n_s = al_wdata_s;
                    end
                end else begin
                    mem_req_n_s = 1'b0;
                end
            end
            ST_REQ: begin
                if (mem_gnt) begin
                    mem_req_n_s = 1'b0;
                    if (store_r) begin
                        rsp_valid_n_s = 1'b1;
                        rsp_fault_n_s = 1'b0;
                        rsp_data_n_s  = 32'h0000_0000;
                    end else begin
                        rsp_valid_n_s = 1'b0;
                    end
                end else begin
                    mem_req_n_s = 1'b1;
                end
            end
            ST_WAIT: begin
                if (mem_rvalid) begin
                    rsp_valid_n_s = 1'b1;
                    rsp_fault_n_s = 1'b0;
                    rsp_data_n_s  = al_load_s;
                end else begin
                    rsp_valid_n_s = 1'b0;
                end
            end
            ST_RESP: begin
                rsp_valid_n_s = 1'b0;
            end
            default: begin
                mem_req_n_s   = 1'b0;
                rsp_valid_n_s = 1'b0;
            end
        endcase
    end

    // Output and op-field registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            store_r     <= 1'b0;
            funct3_r    <= 3'b000;
            addr_lo_r   <= 2'b00;
            req_ready_r <= 1'b1;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= 32'h0000_0000;
            mem_be_r    <= 4'b0000;
            mem_wdata_r <= 32'h0000_0000;
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= 32'h0000_0000;
            rsp_fault_r <= 1'b0;
        end else begin
            store_r     <= store_n_s;
            funct3_r    <= funct3_n_s;
            addr_lo_r   <= addr_lo_n_s;
            req_ready_r <= req_ready_n_s;
            mem_req_r   <= mem_req_n_s;
            mem_we_r    <= mem_we_n_s;
            mem_addr_r  <= mem_addr_n_s;
            mem_be_r    <= mem_be_n_s;
            mem_wdata_r <= mem_wdata_n_s;
            rsp_valid_r <= rsp_valid_n_s;
            rsp_data_r  <= rsp_data_n_s;
            rsp_fault_r <= rsp_fault_n_s;
        end
    end

    assign req_ready = req_ready_r;
    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_be    = mem_be_r;
    assign mem_wdata = mem_wdata_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = rsp_data_r;
    assign rsp_fault = rsp_fault_r;

endmodule

// File: tb/tb_lsu.sv
// Directed testbench for lsu: stores, loads with extension, faults, stalls and reset.
`timescale 1ns/1ps

module tb_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_fault;

    int vec_cnt = 0;
    int err_cnt = 0;

    lsu dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_fault  (rsp_fault)
    );

    // Free-running 100 MHz clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_req(input string tag, input logic st, input logic [31:0] addr,
                           input logic [3:0] be, input logic [31:0] wd);
        chk({tag, "/mem_req"},   32'(mem_req),   32'h1);
        chk({tag, "/mem_we"},    32'(mem_we),    32'(st));
        chk({tag, "/mem_addr"},  mem_addr,       {addr[31:2], 2'b00});
        chk({tag, "/mem_be"},    32'(mem_be),    32'(be));
        chk({tag, "/mem_wdata"}, mem_wdata,      wd);
        chk({tag, "/ready"},     32'(req_ready), 32'h0);
        chk({tag, "/rsp_valid"}, 32'(rsp_valid), 32'h0);
    endtask

    // One complete op: accept, optional grant/rvalid stalls, one response pulse
    task automatic run_op(input string tag, input logic st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                          input logic [3:0] exp_be, input logic [31:0] exp_wd,
                          input logic [31:0] exp_rsp, input logic exp_fault,
                          input int gnt_wait, input int rv_wait);
        chk({tag, "/ready_c0"}, 32'(req_ready), 32'h1);
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        tick();
        req_valid = 1'b0;
        if (exp_fault) begin
            chk({tag, "/f_mem_req"}, 32'(mem_req),   32'h0);
            chk({tag, "/f_rsp_vld"}, 32'(rsp_valid), 32'h1);
            chk({tag, "/f_fault"},   32'(rsp_fault), 32'h1);
            chk({tag, "/f_data"},    rsp_data,       32'h0);
            tick();
            chk({tag, "/f_mem_req2"}, 32'(mem_req),   32'h0);
            chk({tag, "/f_rsp_end"},  32'(rsp_valid), 32'h0);
            chk({tag, "/f_ready"},    32'(req_ready), 32'h1);
        end else begin
            for (int i = 0; i < gnt_wait; i++) begin
                chk_req({tag, "/gstall"}, st, addr, exp_be, exp_wd);
                tick();
            end
            chk_req(tag, st, addr, exp_be, exp_wd);
            mem_gnt = 1'b1;
            tick();
            mem_gnt = 1'b0;
            if (!st) begin
                chk({tag, "/wait_req"}, 32'(mem_req), 32'h0);
                for (int i = 0; i < rv_wait; i++) begin
                    chk({tag, "/rstall_vld"},   32'(rsp_valid), 32'h0);
                    chk({tag, "/rstall_ready"}, 32'(req_ready), 32'h0);
                    tick();
                end
                mem_rvalid = 1'b1;
                mem_rdata  = rd;
                tick();
                mem_rvalid = 1'b0;
                mem_rdata  = 32'h0;
            end
            chk({tag, "/rsp_vld"},   32'(rsp_valid), 32'h1);
            chk({tag, "/rsp_fault"}, 32'(rsp_fault), 32'h0);
            chk({tag, "/rsp_data"},  rsp_data,       exp_rsp);
            chk({tag, "/rsp_ready"}, 32'(req_ready), 32'h0);
            tick();
            chk({tag, "/rsp_end"},   32'(rsp_valid), 32'h0);
            chk({tag, "/ready_end"}, 32'(req_ready), 32'h1);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_store  = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        tick();
        tick();
        chk("rst/ready",     32'(req_ready), 32'h1);
        chk("rst/mem_req",   32'(mem_req),   32'h0);
        chk("rst/mem_we",    32'(mem_we),    32'h0);
        chk("rst/mem_be",    32'(mem_be),    32'h0);
        chk("rst/rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst/rsp_data",  rsp_data,       32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        //     tag     st    f3      addr          wdata         rdata         be       exp wdata     exp rsp       flt   gw rw
        run_op("sw",   1'b1, 3'b010, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0,        4'b1111, 32'hDEAD_BEEF, 32'h0,        1'b0, 0, 0);
        run_op("sb",   1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 32'h0,        4'b1000, 32'hA5A5_A5A5, 32'h0,        1'b0, 0, 0);
        run_op("sh",   1'b1, 3'b001, 32'h0000_1002, 32'h0000_1234, 32'h0,        4'b1100, 32'h1234_1234, 32'h0,        1'b0, 0, 0);
        run_op("lb",   1'b0, 3'b000, 32'h0000_1001, 32'h0,         32'h0000_8000, 4'b0010, 32'h0,        32'hFFFF_FF80, 1'b0, 0, 0);
        run_op("lbu",  1'b0, 3'b100, 32'h0000_1001, 32'h0,         32'h0000_8000, 4'b0010, 32'h0,        32'h0000_0080, 1'b0, 0, 0);
        run_op("lh",   1'b0, 3'b001, 32'h0000_1002, 32'h0,         32'h8001_0000, 4'b1100, 32'h0,        32'hFFFF_8001, 1'b0, 0, 0);
        run_op("lhu",  1'b0, 3'b101, 32'h0000_1002, 32'h0,         32'h8001_0000, 4'b1100, 32'h0,        32'h0000_8001, 1'b0, 0, 0);
        run_op("lw_st",1'b0, 3'b010, 32'h0000_2004, 32'h0,         32'h1234_5678, 4'b1111, 32'h0,        32'h1234_5678, 1'b0, 3, 2);
        run_op("sb_st",1'b1, 3'b000, 32'h0000_3001, 32'h0000_0077, 32'h0,        4'b0010, 32'h7777_7777, 32'h0,        1'b0, 2, 0);
        run_op("lw_mis",1'b0,3'b010, 32'h0000_1002, 32'h0,         32'h0,        4'b0000, 32'h0,        32'h0,        1'b1, 0, 0);
        run_op("l011", 1'b0, 3'b011, 32'h0000_1000, 32'h0,         32'h0,        4'b0000, 32'h0,        32'h0,        1'b1, 0, 0);
        run_op("lh_mis",1'b0,3'b001, 32'h0000_1001, 32'h0,         32'h0,        4'b0000, 32'h0,        32'h0,        1'b1, 0, 0);
        run_op("s100", 1'b1, 3'b100, 32'h0000_1000, 32'h0000_0011, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b1, 0, 0);

        // Reset while waiting for load data; a late rvalid must be ignored
        req_valid  = 1'b1;
        req_store  = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h0000_2000;
        tick();
        req_valid = 1'b0;
        mem_gnt   = 1'b1;
        tick();
        mem_gnt = 1'b0;
        chk("rw/ready_wait", 32'(req_ready), 32'h0);
        rst_n = 1'b0;
        #1;
        chk("rw/mem_req",   32'(mem_req),   32'h0);
        chk("rw/rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rw/ready",     32'(req_ready), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hFFFF_FFFF;
        tick();
        mem_rvalid = 1'b0;
        chk("rw/late_vld",  32'(rsp_valid), 32'h0);
        chk("rw/late_rdy",  32'(req_ready), 32'h1);
        tick();
        chk("rw/late_vld2", 32'(rsp_valid), 32'h0);

        // Reset while the request is on the bus drops mem_req at once
        req_valid  = 1'b1;
        req_store  = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h0000_4000;
        req_wdata  = 32'hCAFE_F00D;
        tick();
        req_valid = 1'b0;
        chk("rq/mem_req_on", 32'(mem_req), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rq/mem_req_off", 32'(mem_req),   32'h0);
        chk("rq/ready",       32'(req_ready), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("rq/rsp_valid", 32'(rsp_valid), 32'h0);

        run_op("sh_rec", 1'b1, 3'b001, 32'h0000_5000, 32'h0000_BEEF, 32'h0, 4'b0011, 32'hBEEF_BEEF, 32'h0, 1'b0, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
